// File: rtl/ps2_move_decoder.sv
// ps2_move_decoder: PS/2 receiver and scancode decoder driving held move_* levels
// for the arrow keys and W/A/S/D.
module ps2_move_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       move_up,
  output logic       move_down,
  output logic       move_right,
  output logic       move_left,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  logic [1:0]    pclk_q, pdat_q;
  logic          sclk, sdat;
  logic          filt_q, filt_d, differ, flip, fall;
  logic [FW-1:0] fcnt_q, fcnt_d;
  rx_state_e     st_q, st_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d, code_q, code_d;
  logic          par_q, par_d, vld_q, vld_d, err_q, err_d, timeout;
  logic [TW-1:0] to_q, to_d;
  logic          ext_q, ext_d, brk_q, brk_d, hit;
  logic [2:0]    idx;
  logic [7:0]    held_q, held_d;
  logic [3:0]    mv_q, mv_d;

  assign sclk = pclk_q[1];
  assign sdat = pdat_q[1];

  // The filtered level only flips on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    differ = sclk != filt_q;
    flip   = differ && fcnt_q == FW'(FILTER_LEN - 1);
    fcnt_d = (!differ || flip) ? '0 : fcnt_q + 1'b1;
    filt_d = flip ? sclk : filt_q;
    fall   = flip && filt_q;
  end

  always_comb begin
    st_d    = st_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    code_d  = code_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    to_d    = (st_q == RX_IDLE || fall) ? '0 : to_q + 1'b1;
    timeout = st_q != RX_IDLE && !fall && to_q == TW'(TIMEOUT_CYCLES - 1);
    if (timeout) begin
      st_d  = RX_IDLE;
      err_d = 1'b1;
      to_d  = '0;
    end else if (fall) begin
      case (st_q)
        RX_IDLE: if (!sdat) begin
          st_d  = RX_DATA;
          bit_d = 3'd0;
        end
        RX_DATA: begin
          sh_d  = {sdat, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          st_d  = bit_q == 3'd7 ? RX_PARITY : RX_DATA;
        end
        RX_PARITY: begin
          par_d = sdat;
          st_d  = RX_STOP;
        end
        RX_STOP: begin
          st_d = RX_IDLE;
          if (sdat && ^{sh_q, par_q}) begin
            code_d = sh_q;
            vld_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Held bits: 0..3 = Up/Down/Right/Left arrows, 4..7 = W/S/D/A.
  always_comb begin
    hit = 1'b1;
    idx = 3'd0;
    case ({ext_q, code_q})
      9'h175:  idx = 3'd0;
      9'h172:  idx = 3'd1;
      9'h174:  idx = 3'd2;
      9'h16B:  idx = 3'd3;
      9'h01D:  idx = 3'd4;
      9'h01B:  idx = 3'd5;
      9'h023:  idx = 3'd6;
      9'h01C:  idx = 3'd7;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    held_d = held_q;
    if (err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (vld_q) begin
      if (code_q == 8'hE0) ext_d = 1'b1;
      else if (code_q == 8'hF0) brk_d = 1'b1;
      else begin
        if (hit) held_d[idx] = ~brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    mv_d = {held_d[3] | held_d[7], held_d[2] | held_d[6], held_d[1] | held_d[5], held_d[0] | held_d[4]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_q <= 2'b11;
      pdat_q <= 2'b11;
      filt_q <= 1'b1;
      fcnt_q <= '0;
      st_q   <= RX_IDLE;
      bit_q  <= 3'd0;
      sh_q   <= 8'h00;
      par_q  <= 1'b0;
      to_q   <= '0;
      code_q <= 8'h00;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      held_q <= 8'h00;
      mv_q   <= 4'h0;
    end else begin
      pclk_q <= {pclk_q[0], ps2_clk};
      pdat_q <= {pdat_q[0], ps2_data};
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      st_q   <= st_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      to_q   <= to_d;
      code_q <= code_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      held_q <= held_d;
      mv_q   <= mv_d;
    end
  end

  assign {move_left, move_right, move_down, move_up} = mv_q;
  assign scancode       = code_q;
  assign scancode_valid = vld_q;
  assign frame_err      = err_q;
endmodule

// File: tb/tb_ps2_move_decoder.sv
// tb_ps2_move_decoder: scoreboard bench; a key-set model predicts each received byte,
// error and the resulting move_* levels.
`timescale 1ns/1ps
module tb_ps2_move_decoder;
  localparam int FL   = 4;
  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       move_up, move_down, move_right, move_left;
  logic [7:0] scancode;
  logic       scancode_valid, frame_err;

  ps2_move_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .move_up(move_up), .move_down(move_down), .move_right(move_right), .move_left(move_left),
    .scancode(scancode), .scancode_valid(scancode_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic [3:0] mv;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  bit         pressed[int];
  bit         m_ext, m_brk;
  logic [7:0] m_code = 8'h00;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  // Direction of a key (ext*256 + code): 0 up, 1 down, 2 right, 3 left, -1 unknown.
  function automatic int dir_of(input int k);
    case (k)
      'h175, 'h01D: return 0;
      'h172, 'h01B: return 1;
      'h174, 'h023: return 2;
      'h16B, 'h01C: return 3;
      default:      return -1;
    endcase
  endfunction

  function automatic logic [3:0] cur_moves();
    logic [3:0] m;
    m = 4'h0;
    foreach (pressed[k]) if (pressed[k] && dir_of(k) >= 0) m[dir_of(k)] = 1'b1;
    return m;
  endfunction

  task automatic model(input logic [7:0] b, input bit ok);
    exp_t e;
    int   k;
    if (!ok) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      m_code = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        k = (m_ext ? 256 : 0) + int'(b);
        if (dir_of(k) >= 0) pressed[k] = !m_brk;
        m_ext = 0;
        m_brk = 0;
      end
    end
    e.is_err = !ok;
    e.code   = m_code;
    e.mv     = cur_moves();
    sb.push_back(e);
  endtask

  task automatic ps2_bit(input logic d, input bit gl);
    ps2_data = d;
    repeat (6) @(negedge clk);
    if (gl) begin
      ps2_clk = 1'b0;
      repeat (FL - 1) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit gl);
    model(b, !(bad_par || bad_stop));
    ps2_bit(1'b0, gl);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], gl);
    ps2_bit(~^b ^ bad_par, gl);
    ps2_bit(~bad_stop, gl);
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops one expectation per valid/err pulse; move_* must still hold the old
  // value in the pulse cycle and take the new value in the next one.
  logic [3:0] prev_mv = 4'h0;
  logic [3:0] pexp;
  bit         pend = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      pend    = 0;
      prev_mv = 4'h0;
    end else begin
      if (pend) begin
        chk("mv_after", {move_left, move_right, move_down, move_up}, pexp);
        pend = 0;
      end
      if (scancode_valid || frame_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {scancode_valid, frame_err}, 2'b00);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", {scancode_valid, frame_err}, {!e.is_err, e.is_err});
          chk("scancode", scancode, e.code);
          chk("mv_hold", {move_left, move_right, move_down, move_up}, prev_mv);
          pexp    = e.mv;
          prev_mv = e.mv;
          pend    = 1;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  logic [7:0] pool[12];
  initial begin
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h74, 8'h6B, 8'h1D, 8'h1B, 8'h23, 8'h1C, 8'hE1, 8'h00};
    for (int i = 0; i < 12; i++) begin
      ps2_clk  = 1'($urandom);
      ps2_data = 1'($urandom);
      @(negedge clk);
      chk("reset_outs", {move_up, move_down, move_right, move_left, scancode_valid, frame_err, scancode}, 0);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h1D); send(8'hE0); send(8'h75); send(8'hF0); send(8'h1D);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h1C); send(8'hE0); send(8'h74);
    send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h74);
    send_frame(8'h75, 1'b1, 1'b0, 1'b0);
    send(8'h1B); send(8'hF0); send(8'h1B);
    model(8'h00, 1'b0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (TO + 100) @(negedge clk);
    chk("timeout_drained", sb.size(), 0);
    send(8'h23); send(8'hF0); send(8'h23);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b0, 1'b1);
    chk("glitch_up", move_up, 1'b1);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 chk("async_reset", {move_up, move_down, move_right, move_left, scancode_valid, frame_err, scancode}, 0);
    pressed.delete();
    sb.delete();
    m_ext    = 0;
    m_brk    = 0;
    m_code   = 8'h00;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send(8'h1C);
    chk("left_after_reset", {move_left, move_right, move_down, move_up}, 4'b1000);
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      b = pool[$urandom_range(0, 11)];
      if (b == 8'h00) b = 8'($urandom);
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
